// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^M) multiply/divide unit: FSM encoding,
// mode constants and default field polynomials.
package gf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } gf_state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  localparam logic [4:0] POLY_M4 = 5'h13;
  localparam logic [8:0] POLY_M8 = 9'h11B;

endpackage

// File: rtl/gf_serial_mult.sv
// Bit-serial MSB-first GF(2^M) multiplier. The start edge loads the operands
// and already processes bit M-1, so p is final M edges after start.
module gf_serial_mult #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] p
);

  localparam int            CW   = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [M-1:0]  a_q;
  logic [M-1:0]  b_q;
  logic [CW-1:0] bit_cnt;

  function automatic logic [M-1:0] mac_step(input logic [M-1:0] acc,
                                            input logic [M-1:0] addend,
                                            input logic         bit_b);
    logic [M:0] t;
    t = {acc, 1'b0};
    if (t[M]) t = t ^ POLY;
    return t[M-1:0] ^ (bit_b ? addend : '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      p       <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q     <= a;
        b_q     <= b << 1;
        p       <= mac_step('0, a, b[M-1]);
        bit_cnt <= CW'(1);
        busy    <= 1'b1;
      end else if (busy) begin
        p   <= mac_step(p, a_q, b_q[M-1]);
        b_q <= b_q << 1;
        if (bit_cnt == LAST) begin
          bit_cnt <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gf_muldiv_seq.sv
// Sequential GF(2^M) multiply / divide unit with valid/ready handshakes.
// Division is a*b^(2^M-2), evaluated as M square-and-multiply steps.
module gf_muldiv_seq
  import gf_pkg::*;
#(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = POLY_M8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [M-1:0] op_a,
  input  logic [M-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] result,
  output logic         div_by_zero
);

  localparam int            CW   = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  gf_state_t     state_q, state_d;
  logic [CW-1:0] step_q;
  logic [M-1:0]  result_q;
  logic          dbz_q;
  logic          start0, start1, busy0, busy1, done0, done1;
  logic [M-1:0]  m0_a, m0_b, m1_a, m1_b, p0, p1;
  logic          accept, div_zero, step_done, last_step;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign accept      = in_valid && in_ready;
  assign div_zero    = (mode == MODE_DIV) && (op_b == '0);
  assign step_done   = done0 && done1;
  assign last_step   = (step_q == LAST);

  // Launch takes operands straight from the ports; later Fermat steps chain
  // the previous products so a step restarts on the same edge it finishes.
  always_comb begin
    m0_a = p0;
    m0_b = p0;
    m1_a = p1;
    m1_b = p0;
    if (state_q == ST_IDLE) begin
      m0_a = (mode == MODE_MUL) ? op_a : op_b;
      m0_b = op_b;
      m1_a = op_a;
      m1_b = M'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start0  = 1'b0;
    start1  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (div_zero) begin
            state_d = ST_DONE;
          end else if (mode == MODE_MUL) begin
            state_d = ST_MUL;
            start0  = !busy0;
          end else begin
            state_d = ST_DIV;
            start0  = !busy0;
            start1  = !busy1;
          end
        end
      end
      ST_MUL:  if (done0) state_d = ST_DONE;
      ST_DIV: begin
        if (step_done) begin
          if (last_step) begin
            state_d = ST_DONE;
          end else begin
            start0 = 1'b1;
            start1 = 1'b1;
          end
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      if (accept) begin
        step_q <= '0;
      end else if (state_q == ST_DIV && step_done) begin
        step_q <= last_step ? '0 : step_q + CW'(1);
      end
      if (accept && div_zero) begin
        result_q <= '0;
        dbz_q    <= 1'b1;
      end else if (state_q == ST_MUL && done0) begin
        result_q <= p0;
        dbz_q    <= 1'b0;
      end else if (state_q == ST_DIV && step_done && last_step) begin
        result_q <= p1;
        dbz_q    <= 1'b0;
      end
    end
  end

  // Instance 0: plain multiply and the squaring chain; instance 1: accumulator.
  gf_serial_mult #(.M(M), .POLY(POLY)) u_mult_sq (
    .clk(clk), .rst(rst), .start(start0), .a(m0_a), .b(m0_b),
    .busy(busy0), .done(done0), .p(p0)
  );

  gf_serial_mult #(.M(M), .POLY(POLY)) u_mult_acc (
    .clk(clk), .rst(rst), .start(start1), .a(m1_a), .b(m1_b),
    .busy(busy1), .done(done1), .p(p1)
  );

endmodule

// File: tb/tb_gf_muldiv_seq.sv
// Directed bench for gf_muldiv_seq: GF(2^8) vector table, backpressure,
// mid-divide reset, and a GF(2^4) instance with an exhaustive round trip.
module tb_gf_muldiv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv8, ir8, mode8, ov8, ordy8, dbz8;
  logic [7:0] a8, b8, res8;
  logic       iv4, ir4, mode4, ov4, ordy4, dbz4;
  logic [3:0] a4, b4, res4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf_muldiv_seq #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .mode(mode8),
    .op_a(a8), .op_b(b8), .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .div_by_zero(dbz8)
  );

  gf_muldiv_seq #(.M(4), .POLY(5'h13)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .mode(mode4),
    .op_a(a4), .op_b(b4), .out_valid(ov4), .out_ready(ordy4),
    .result(res4), .div_by_zero(dbz4)
  );

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_dbz;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for out_valid; returns at a negedge.
  task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] r, output logic z, output int lat);
    @(negedge clk);
    check("m8_in_ready_before_accept", {31'd0, ir8}, 32'd1);
    mode8 = m; a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    r = res8;
    z = dbz8;
  endtask

  task automatic consume8();
    ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy8 = 1'b0;
    check("m8_in_ready_after_accept", {31'd0, ir8}, 32'd1);
    check("m8_out_valid_after_accept", {31'd0, ov8}, 32'd0);
  endtask

  task automatic op4(input logic m, input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] r, output logic z, output int lat);
    @(negedge clk);
    mode4 = m; a4 = a; b4 = b; iv4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    lat = 1;
    while (!ov4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = res4;
    z = dbz4;
    ordy4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy4 = 1'b0;
  endtask

  initial begin
    logic [7:0] r8;
    logic [3:0] r4, q4;
    logic       z;
    int         lat;

    vecs[0] = '{1'b0, 8'h57, 8'h83, 8'hC1, 1'b0, 9};
    vecs[1] = '{1'b1, 8'h01, 8'h53, 8'hCA, 1'b0, 65};
    vecs[2] = '{1'b1, 8'hC1, 8'h83, 8'h57, 1'b0, 65};
    vecs[3] = '{1'b1, 8'h5A, 8'h00, 8'h00, 1'b1, 1};
    vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 9};
    vecs[5] = '{1'b0, 8'h02, 8'h80, 8'h1B, 1'b0, 9};
    vecs[6] = '{1'b0, 8'h53, 8'hCA, 8'h01, 1'b0, 9};
    vecs[7] = '{1'b1, 8'h57, 8'h01, 8'h57, 1'b0, 65};

    rst = 1'b1;
    iv8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0; ordy8 = 1'b0;
    iv4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0; ordy4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, ir8}, 32'd1);
    check("reset_out_valid", {31'd0, ov8}, 32'd0);
    check("reset_result", {24'd0, res8}, 32'd0);
    check("reset_div_by_zero", {31'd0, dbz8}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].mode, vecs[i].a, vecs[i].b, r8, z, lat);
      check($sformatf("vec%0d_result", i), {24'd0, r8}, {24'd0, vecs[i].exp_res});
      check($sformatf("vec%0d_div_by_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_dbz});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      consume8();
    end

    // Backpressure: result held, new requests ignored while DONE.
    op8(1'b0, 8'h57, 8'h83, r8, z, lat);
    for (int c = 0; c < 20; c++) begin
      iv8 = c[0]; mode8 = 1'b1; a8 = 8'h11; b8 = 8'h00;
      @(negedge clk);
      check("bp_result_stable", {24'd0, res8}, 32'h0000_00C1);
      check("bp_in_ready_low", {31'd0, ir8}, 32'd0);
      check("bp_out_valid_high", {31'd0, ov8}, 32'd1);
    end
    iv8 = 1'b0;
    check("bp_div_by_zero_low", {31'd0, dbz8}, 32'd0);
    consume8();

    // Reset in the middle of a divide.
    @(negedge clk);
    mode8 = 1'b1; a8 = 8'h01; b8 = 8'h53; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (29) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, ov8}, 32'd0);
    check("midrst_in_ready", {31'd0, ir8}, 32'd1);
    check("midrst_result", {24'd0, res8}, 32'd0);
    check("midrst_div_by_zero", {31'd0, dbz8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op8(1'b0, 8'h02, 8'h80, r8, z, lat);
    check("postrst_result", {24'd0, r8}, 32'h0000_001B);
    check("postrst_latency", lat, 9);
    consume8();

    // GF(2^4), POLY = x^4 + x + 1.
    op4(1'b0, 4'h3, 4'h7, r4, z, lat);
    check("m4_mul_result", {28'd0, r4}, 32'h9);
    check("m4_mul_latency", lat, 5);
    op4(1'b1, 4'h9, 4'h0, r4, z, lat);
    check("m4_divzero_result", {28'd0, r4}, 32'h0);
    check("m4_divzero_flag", {31'd0, z}, 32'd1);
    check("m4_divzero_latency", lat, 1);
    op4(1'b1, 4'h9, 4'h7, r4, z, lat);
    check("m4_div_latency", lat, 17);
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        op4(1'b0, 4'(a), 4'(b), r4, z, lat);
        op4(1'b1, r4, 4'(b), q4, z, lat);
        check($sformatf("m4_roundtrip_a%0d_b%0d", a, b), {28'd0, q4}, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_muldiv_seq.md
# gf_muldiv_seq

Sequential, parametrised GF(2^M) arithmetic unit that computes either a·b or a/b over a field defined by an irreducible polynomial POLY. It uses bit-serial multiplication with a valid/ready handshake on both sides. It is the multi-cycle, area-lean successor to the team's single-cycle combinational GF(2^8) multiplier. It targets datapaths such as RS/BCH codecs and AES key/S-box logic that need division without a lookup table.

## Interface
- M, 8, field degree (2..16)
- POLY, 9'h11B, irreducible polynomial, M+1 bits, bit M must be 1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  unit idle, will accept operands
- mode  in  1  0 = multiply (a·b), 1 = divide (a/b)
- op_a  in  M  operand a
- op_b  in  M  operand b
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  M  field result
- div_by_zero  out  1  qualifies result: divide with op_b == 0

## Operation
- Accept: the handshake completes on a rising edge with in_valid && in_ready. At that edge mode, op_a and op_b are registered, and the inputs are then ignored until the next accept.
- FSM states:
  - IDLE: in_ready = 1.
  - MUL: single multiply, M cycles.
  - DIV: M steps of M cycles each.
  - DONE: out_valid = 1.
- Transitions:
  - IDLE goes to MUL (mode 0), to DIV (mode 1 with op_b ≠ 0), or directly to DONE (mode 1 with op_b == 0).
  - DONE goes to IDLE on out_ready.
- Multiply: MSB-first shift-and-add. For each bit j of b from bit M-1 down to bit 0:
  - p = (p<<1), reduced by POLY if bit M is set;
  - then p = p ^ (b[j] ? a : 0).
  - All arithmetic is XOR; no intermediate ever exceeds M+1 bits.
- Divide: a/b = a·b^(2^M−2) by Fermat.
  - Initial values: acc = a, sq = b.
  - Each step k = 0..M−1 runs two multiplies in parallel: sq ← sq·sq and acc ← acc·(k == 0 ? 1 : sq).
  - Both use the value of sq from before the step.
  - After step M−1, result = acc.
- Divide by zero: result = 0 and div_by_zero = 1, with no computation. div_by_zero is 0 for every other result.
- Multiply by zero runs the full M cycles and returns 0.
- result and div_by_zero are registered and stable for the whole time out_valid is high.
- Reset, asynchronous at any time including mid-operation:
  - The FSM goes to IDLE and all internal registers clear.
  - Any in-flight operation is discarded with no output.
  - Reset values: in_ready = 1, out_valid = 0, result = 0, div_by_zero = 0.

## Timing
- Accept edge = edge 0.
- Multiply: out_valid rises after edge M+1, so latency is M+1 cycles (9 for M = 8).
- Divide, b ≠ 0: out_valid rises after edge M·M+1 (65 for M = 8).
- Divide, b == 0: out_valid rises after edge 1.
- out_valid stays high until an edge with out_ready = 1. The FSM returns to IDLE at that edge, and in_ready is 1 in the following cycle. This gives no back-to-back overlap, so maximum throughput is one operation per latency+1 cycles.
- If out_ready is already high when out_valid rises, the result is visible for exactly one cycle.
- in_ready is a combinational decode of state == IDLE. There is no combinational path from in_valid or out_ready to any output.
- Counters: bit counter and step counter are each $clog2(M) bits. Each wraps at M−1 and clears on entry to MUL or DIV.

## Structure
- Shared package gf_pkg holds:
  - the FSM state encoding (IDLE, MUL, DIV, DONE);
  - the mode constants MODE_MUL = 0 and MODE_DIV = 1;
  - the default POLY for M = 4 (5'h13) and for M = 8 (9'h11B).
- Sub-module gf_serial_mult (M, POLY):
  - Ports: clk, rst, start, a, b, busy, done, p.
  - Behaviour: computes a·b in M cycles; done is a 1-cycle pulse aligned with the valid p.
- Instantiation: two instances of gf_serial_mult. Instance 0 serves MUL mode and the sq path; instance 1 serves the acc path. The top level is the FSM, the step counter and the output registers.

## Test plan
- M = 8, POLY = 11B, mode 0, a = 0x57, b = 0x83 -> result 0xC1, div_by_zero = 0, out_valid 9 cycles after accept.
- M = 8, mode 1, a = 0x01, b = 0x53 -> result 0xCA (the inverse of 0x53); a = 0xC1, b = 0x83 -> result 0x57. Each takes 65 cycles.
- M = 8, mode 1, b = 0x00, a = 0x5A -> result 0x00, div_by_zero = 1, out_valid 1 cycle after accept. Follow with mode 0, a = 0x00, b = 0xFF -> result 0x00, div_by_zero = 0.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid. Required: result is stable, in_ready = 0, and in_valid pulses are ignored. Raising out_ready then gives in_ready = 1 on the next cycle.
- Reset mid-divide: assert rst at cycle 30 of a divide. Required: out_valid = 0, in_ready = 1 and result = 0 immediately. The next multiply, 0x02·0x80, gives 0x1B.
- M = 4, POLY = 5'h13: mode 0, a = 0x3, b = 0x7 -> result 0x9. Exhaustive check: for every b ≠ 0, (a·b)/b == a.
